// File: rtl/icache_miss_ctrl_pkg.sv
// rtl/icache_miss_ctrl_pkg.sv - shared widths and types for the icache line-fill controller
package icache_miss_ctrl_pkg;

    localparam int PA_WIDTH                  = 34;
    localparam int ICACHE_INDEX_WIDTH        = 7;
    localparam int ICACHE_TAG_WIDTH          = 22;
    localparam int ICACHE_BLOCK_SIZE         = 32;
    localparam int ICACHE_FETCH_WIDTH        = 16;
    localparam int ICACHE_BLOCK_OFFSET_WIDTH = 5;
    localparam int ICACHE_FETCH_BITS         = ICACHE_FETCH_WIDTH * 8;
    localparam int ICACHE_PA_BLK_WIDTH       = PA_WIDTH - ICACHE_BLOCK_OFFSET_WIDTH;
    // A line arrives as this many fetch-width beats; the FSM hard-codes two beat states.
    localparam int ICACHE_FILL_BEATS         = ICACHE_BLOCK_SIZE / ICACHE_FETCH_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        BEAT0,
        BEAT1,
        INSTALL
    } icache_miss_state_t;

    typedef struct packed {
        logic [ICACHE_TAG_WIDTH-1:0]   tag;
        logic [ICACHE_INDEX_WIDTH-1:0] index;
        logic                          way;
        logic                          blkoff;
    } icache_miss_req_t;

endpackage

// File: rtl/icache_miss_ctrl.sv
// rtl/icache_miss_ctrl.sv - icache line-fill sequencer between icache and l2_cache
module icache_miss_ctrl
    import icache_miss_ctrl_pkg::*;
#(
    parameter bit FWD_CRITICAL = 1'b1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           miss_valid,
    output logic                           miss_ready,
    input  logic [ICACHE_TAG_WIDTH-1:0]    miss_tag,
    input  logic [ICACHE_INDEX_WIDTH-1:0]  miss_index,
    input  logic                           miss_way,
    input  logic                           miss_blkoff,
    input  logic                           kill,
    output logic                           l2_req_valid,
    input  logic                           l2_req_ready,
    output logic [ICACHE_PA_BLK_WIDTH-1:0] l2_req_pa_blk,
    output logic                           l2_req_blkoff,
    input  logic                           l2_resp_valid,
    input  logic [ICACHE_FETCH_BITS-1:0]   l2_resp_data,
    output logic                           data_we,
    output logic [ICACHE_INDEX_WIDTH-1:0]  data_index,
    output logic                           data_way,
    output logic                           data_blkoff,
    output logic [ICACHE_FETCH_BITS-1:0]   data_wdata,
    output logic                           tag_we,
    output logic [ICACHE_INDEX_WIDTH-1:0]  tag_index,
    output logic                           tag_way,
    output logic [ICACHE_TAG_WIDTH-1:0]    tag_wdata,
    output logic                           fwd_valid,
    output logic [ICACHE_FETCH_BITS-1:0]   fwd_data,
    output logic                           fill_done
);

    icache_miss_state_t state;
    icache_miss_state_t state_nxt;
    icache_miss_req_t   req_q;
    logic               killed;
    logic               accept;

    assign accept = miss_valid && miss_ready;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the accepted miss; remember a redirect seen while the fill is in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_q  <= '0;
            killed <= 1'b0;
        end else if (accept) begin
            // A kill in the accept cycle targets the previous miss, so the new one starts clean.
            req_q  <= '{tag: miss_tag, index: miss_index, way: miss_way, blkoff: miss_blkoff};
            killed <= 1'b0;
        end else if (kill && (state != IDLE)) begin
            killed <= 1'b1;
        end
    end

    // Next-state: request, two beats, then install tag last
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = REQ;
            REQ:     if (l2_req_ready)  state_nxt = BEAT0;
            BEAT0:   if (l2_resp_valid) state_nxt = BEAT1;
            BEAT1:   if (l2_resp_valid) state_nxt = INSTALL;
            INSTALL:                    state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Outputs: array writes follow the response combinationally; write data is zero when idle
    always_comb begin
        miss_ready    = (state == IDLE);
        l2_req_valid  = (state == REQ);
        l2_req_pa_blk = {req_q.tag, req_q.index};
        l2_req_blkoff = req_q.blkoff;
        data_we       = 1'b0;
        data_index    = req_q.index;
        data_way      = req_q.way;
        data_blkoff   = req_q.blkoff;
        data_wdata    = '0;
        tag_we        = 1'b0;
        tag_index     = req_q.index;
        tag_way       = req_q.way;
        tag_wdata     = req_q.tag;
        fwd_valid     = 1'b0;
        fwd_data      = '0;
        fill_done     = 1'b0;
        case (state)
            BEAT0: begin
                if (l2_resp_valid) begin
                    data_we    = 1'b1;
                    data_wdata = l2_resp_data;
                    fwd_valid  = FWD_CRITICAL && !killed && !kill;
                    if (fwd_valid) begin
                        fwd_data = l2_resp_data;
                    end
                end
            end
            BEAT1: begin
                data_blkoff = ~req_q.blkoff;
                if (l2_resp_valid) begin
                    data_we    = 1'b1;
                    data_wdata = l2_resp_data;
                end
            end
            INSTALL: begin
                tag_we    = 1'b1;
                fill_done = !killed && !kill;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// tb/tb_icache_miss_ctrl.sv - randomized self-checking bench for icache_miss_ctrl
module tb_icache_miss_ctrl;
    import icache_miss_ctrl_pkg::*;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         miss_valid, miss_ready;
    logic [21:0]  miss_tag;
    logic [6:0]   miss_index;
    logic         miss_way, miss_blkoff, kill;
    logic         l2_req_valid, l2_req_ready;
    logic [28:0]  l2_req_pa_blk;
    logic         l2_req_blkoff;
    logic         l2_resp_valid;
    logic [127:0] l2_resp_data;
    logic         data_we;
    logic [6:0]   data_index;
    logic         data_way, data_blkoff;
    logic [127:0] data_wdata;
    logic         tag_we;
    logic [6:0]   tag_index;
    logic         tag_way;
    logic [21:0]  tag_wdata;
    logic         fwd_valid;
    logic [127:0] fwd_data;
    logic         fill_done;

    icache_miss_ctrl #(.FWD_CRITICAL(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_tag(miss_tag),
        .miss_index(miss_index), .miss_way(miss_way), .miss_blkoff(miss_blkoff), .kill(kill),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
        .l2_req_pa_blk(l2_req_pa_blk), .l2_req_blkoff(l2_req_blkoff),
        .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
        .data_we(data_we), .data_index(data_index), .data_way(data_way),
        .data_blkoff(data_blkoff), .data_wdata(data_wdata),
        .tag_we(tag_we), .tag_index(tag_index), .tag_way(tag_way), .tag_wdata(tag_wdata),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data), .fill_done(fill_done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { logic blk; logic way; logic [6:0] idx; logic [127:0] d; int c; } wr_t;
    typedef struct { logic way; logic [6:0] idx; logic [21:0] tag; int c; } tw_t;
    typedef struct { logic [28:0] pa; logic blk; } rq_t;

    wr_t          wq[$];
    tw_t          tq[$];
    logic [127:0] fq[$];
    int           dq[$];
    rq_t          rq[$];

    // Observed events are logged mid-cycle, away from the active edge
    always @(negedge CLK) begin
        if (data_we)   wq.push_back('{data_blkoff, data_way, data_index, data_wdata, cyc});
        if (tag_we)    tq.push_back('{tag_way, tag_index, tag_wdata, cyc});
        if (fwd_valid) fq.push_back(fwd_data);
        if (fill_done) dq.push_back(cyc);
        if (l2_req_valid && l2_req_ready) rq.push_back('{l2_req_pa_blk, l2_req_blkoff});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [28:0] exp_pa(input logic [21:0] t, input logic [6:0] i);
        return 29'(t) * 29'd128 + 29'(i);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        wq.delete(); tq.delete(); fq.delete(); dq.delete(); rq.delete();
    endtask

    // Full miss transaction; kmode 0 none, 1 kill in first REQ cycle, 2 kill with beat 1,
    // 3 kill alongside the accept of this miss. acc returns the accept cycle.
    task automatic run_fill(input logic [21:0] t, input logic [6:0] i, input logic w, input logic b,
                            input int rdelay, input int g0, input int g1, input int kmode,
                            input logic [127:0] d0, input logic [127:0] d1, input bit stray,
                            output int acc);
        acc = cyc;
        miss_valid = 1'b1; miss_tag = t; miss_index = i; miss_way = w; miss_blkoff = b;
        kill = (kmode == 3);
        tick();
        miss_valid = 1'b0; miss_tag = $urandom; miss_index = $urandom; kill = (kmode == 1);
        repeat (rdelay) begin tick(); kill = 1'b0; end
        l2_req_ready = 1'b1;
        tick();
        l2_req_ready = 1'b0; kill = 1'b0;
        repeat (g0) tick();
        l2_resp_valid = 1'b1; l2_resp_data = d0;
        tick();
        l2_resp_valid = 1'b0; l2_resp_data = rnd128();
        repeat (g1) tick();
        l2_resp_valid = 1'b1; l2_resp_data = d1; kill = (kmode == 2);
        tick();
        l2_resp_valid = stray; l2_resp_data = rnd128(); kill = 1'b0;
        tick();
        l2_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; miss_valid = 1'b1; kill = 1'b1; l2_req_ready = 1'b1;
        l2_resp_valid = 1'b1; l2_resp_data = rnd128();
        miss_tag = $urandom; miss_index = $urandom; miss_way = 1'b1; miss_blkoff = 1'b1;
        repeat (3) tick();
        @(negedge CLK);
        checks++;
        if (miss_ready !== 1'b1) begin errors++; $display("FAIL reset_miss_ready got %b want 1", miss_ready); end
        checks++;
        if ({l2_req_valid, data_we, tag_we, fwd_valid, fill_done} !== 5'b0) begin
            errors++; $display("FAIL reset_valids got %b want 00000",
                               {l2_req_valid, data_we, tag_we, fwd_valid, fill_done});
        end
        checks++;
        if ({l2_req_pa_blk, data_index, tag_wdata, data_wdata, fwd_data} !== '0) begin
            errors++; $display("FAIL reset_data pa=%h idx=%h tag=%h wd=%h fwd=%h want all 0",
                               l2_req_pa_blk, data_index, tag_wdata, data_wdata, fwd_data);
        end
        miss_valid = 1'b0; kill = 1'b0; l2_req_ready = 1'b0; l2_resp_valid = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        clear_logs();
    endtask

    task automatic test_basic();
        int acc;
        logic [127:0] a, b;
        a = rnd128(); b = rnd128();
        run_fill(22'h2AAAA, 7'h15, 1'b1, 1'b1, 0, 0, 0, 0, a, b, 1'b0, acc);
        checks++;
        if (rq.size() != 1 || rq[0].pa !== exp_pa(22'h2AAAA, 7'h15) || rq[0].blk !== 1'b1) begin
            errors++; $display("FAIL basic_req n=%0d pa=%h want %h",
                               rq.size(), (rq.size() > 0) ? rq[0].pa : 29'h0, exp_pa(22'h2AAAA, 7'h15));
        end
        checks++;
        if (wq.size() != 2) begin
            errors++; $display("FAIL basic_nwrites got %0d want 2", wq.size());
        end else begin
            checks++;
            if (wq[0].blk !== 1'b1 || wq[0].d !== a || wq[0].idx !== 7'h15 || wq[0].way !== 1'b1) begin
                errors++; $display("FAIL basic_beat0 blk=%b idx=%h way=%b d=%h want blk=1 idx=15 way=1 d=%h",
                                   wq[0].blk, wq[0].idx, wq[0].way, wq[0].d, a);
            end
            checks++;
            if (wq[1].blk !== 1'b0 || wq[1].d !== b) begin
                errors++; $display("FAIL basic_beat1 blk=%b d=%h want blk=0 d=%h", wq[1].blk, wq[1].d, b);
            end
        end
        checks++;
        if (tq.size() != 1 || tq[0].tag !== 22'h2AAAA || tq[0].idx !== 7'h15 || tq[0].way !== 1'b1
            || tq[0].c != acc + 4) begin
            errors++; $display("FAIL basic_tag n=%0d want 1 write of tag 2aaaa at cycle %0d", tq.size(), acc + 4);
        end
        checks++;
        if (fq.size() != 1 || fq[0] !== a) begin
            errors++; $display("FAIL basic_fwd n=%0d want 1 with data %h", fq.size(), a);
        end
        checks++;
        if (dq.size() != 1 || dq[0] != acc + 4) begin
            errors++; $display("FAIL basic_done n=%0d cyc=%0d want 1 at %0d",
                               dq.size(), (dq.size() > 0) ? dq[0] : -1, acc + 4);
        end
        clear_logs();
    endtask

    task automatic test_backpressure();
        logic [21:0] t;
        logic [6:0]  i;
        logic [28:0] want;
        t = $urandom; i = $urandom; want = exp_pa(t, i);
        miss_valid = 1'b1; miss_tag = t; miss_index = i; miss_way = 1'b0; miss_blkoff = 1'b0;
        tick();
        // a second miss stays presented and must not be taken while busy
        miss_tag = ~t; miss_index = ~i;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            checks++;
            if (l2_req_valid !== 1'b1 || l2_req_pa_blk !== want || miss_ready !== 1'b0) begin
                errors++; $display("FAIL backpressure_hold k=%0d valid=%b pa=%h ready=%b want 1 %h 0",
                                   k, l2_req_valid, l2_req_pa_blk, miss_ready, want);
            end
            tick();
        end
        miss_valid = 1'b0;
        l2_req_ready = 1'b1; tick(); l2_req_ready = 1'b0;
        l2_resp_valid = 1'b1; l2_resp_data = rnd128(); tick(); tick();
        l2_resp_valid = 1'b0; tick();
        checks++;
        if (tq.size() != 1 || tq[0].tag !== t || dq.size() != 1) begin
            errors++; $display("FAIL backpressure_install tags=%0d done=%0d want 1 1", tq.size(), dq.size());
        end
        clear_logs();
    endtask

    task automatic test_kill();
        int acc;
        run_fill($urandom, $urandom, 1'b0, 1'b1, 2, 1, 0, 1, rnd128(), rnd128(), 1'b0, acc);
        checks++;
        if (wq.size() != 2 || tq.size() != 1) begin
            errors++; $display("FAIL kill_install writes=%0d tags=%0d want 2 1", wq.size(), tq.size());
        end
        checks++;
        if (fq.size() != 0 || dq.size() != 0) begin
            errors++; $display("FAIL kill_suppress fwd=%0d done=%0d want 0 0", fq.size(), dq.size());
        end
        clear_logs();
    endtask

    task automatic test_kill_new_miss();
        int acc;
        logic [127:0] a;
        a = rnd128();
        run_fill($urandom, $urandom, 1'b1, 1'b0, 0, 0, 0, 3, a, rnd128(), 1'b0, acc);
        checks++;
        if (dq.size() != 1 || dq[0] != acc + 4 || fq.size() != 1 || fq[0] !== a) begin
            errors++; $display("FAIL kill_new_miss done=%0d fwd=%0d want 1 1", dq.size(), fq.size());
        end
        clear_logs();
    endtask

    task automatic test_gapped_stray();
        int acc;
        logic [127:0] a, b;
        a = rnd128(); b = rnd128();
        run_fill($urandom, $urandom, 1'b1, 1'b0, 0, 0, 3, 0, a, b, 1'b1, acc);
        checks++;
        if (wq.size() != 2) begin
            errors++; $display("FAIL gapped_nwrites got %0d want 2", wq.size());
        end else begin
            checks++;
            if (wq[0].d !== a || wq[1].d !== b || wq[1].c != acc + 6 || wq[1].blk !== 1'b1) begin
                errors++; $display("FAIL gapped_beats d1=%h c1=%0d blk1=%b want %h %0d 1",
                                   wq[1].d, wq[1].c, wq[1].blk, b, acc + 6);
            end
        end
        checks++;
        if (dq.size() != 1 || dq[0] != acc + 7) begin
            errors++; $display("FAIL gapped_done n=%0d want 1 at %0d", dq.size(), acc + 7);
        end
        clear_logs();
    endtask

    task automatic test_reset_mid_fill();
        int acc;
        miss_valid = 1'b1; miss_tag = $urandom; miss_index = $urandom; miss_way = 1'b1; miss_blkoff = 1'b1;
        tick();
        miss_valid = 1'b0; l2_req_ready = 1'b1; tick(); l2_req_ready = 1'b0;
        l2_resp_valid = 1'b1; l2_resp_data = rnd128(); tick();
        l2_resp_valid = 1'b0; RST = 1'b1; tick(); RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (miss_ready !== 1'b1 || {l2_req_valid, data_we, tag_we, fwd_valid, fill_done} !== 5'b0
            || {l2_req_pa_blk, data_index, tag_index, tag_wdata} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs ready=%b valids=%b pa=%h want 1 00000 0", miss_ready,
                               {l2_req_valid, data_we, tag_we, fwd_valid, fill_done}, l2_req_pa_blk);
        end
        tick(); tick();
        checks++;
        if (tq.size() != 0 || dq.size() != 0 || wq.size() != 1) begin
            errors++; $display("FAIL rst_mid_abandon tags=%0d done=%0d writes=%0d want 0 0 1",
                               tq.size(), dq.size(), wq.size());
        end
        clear_logs();
        run_fill($urandom, $urandom, 1'b0, 1'b0, 1, 0, 0, 0, rnd128(), rnd128(), 1'b0, acc);
        checks++;
        if (tq.size() != 1 || dq.size() != 1 || dq[0] != acc + 5) begin
            errors++; $display("FAIL rst_mid_recover tags=%0d done=%0d want 1 1 at %0d", tq.size(), dq.size(), acc + 5);
        end
        clear_logs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [21:0]  t;
            logic [6:0]   i;
            logic         w, b;
            int           rd, g0, g1, km, acc, lat;
            logic [127:0] d0, d1;
            bit           stray, want_fwd, want_done;
            t = $urandom; i = $urandom; w = $urandom; b = $urandom;
            rd = $urandom_range(0, 3); g0 = $urandom_range(0, 2); g1 = $urandom_range(0, 2);
            km = $urandom_range(0, 3); stray = $urandom_range(0, 1);
            d0 = rnd128(); d1 = rnd128();
            run_fill(t, i, w, b, rd, g0, g1, km, d0, d1, stray, acc);
            want_fwd  = (km != 1);
            want_done = (km == 0 || km == 3);
            lat = 4 + rd + g0 + g1;
            checks++;
            if (rq.size() != 1 || rq[0].pa !== exp_pa(t, i) || rq[0].blk !== b) begin
                errors++; $display("FAIL rand_req n=%0d cnt=%0d want pa %h blk %b", n, rq.size(), exp_pa(t, i), b);
            end
            checks++;
            if (wq.size() != 2 || wq[0].blk !== b || wq[0].d !== d0 || wq[1].blk !== ~b || wq[1].d !== d1
                || wq[0].idx !== i || wq[1].way !== w) begin
                errors++; $display("FAIL rand_writes n=%0d cnt=%0d want 2 ordered beats blk %b then %b", n, wq.size(), b, ~b);
            end
            checks++;
            if (tq.size() != 1 || tq[0].tag !== t || tq[0].idx !== i || tq[0].way !== w || tq[0].c != acc + lat) begin
                errors++; $display("FAIL rand_tag n=%0d cnt=%0d want tag %h at %0d", n, tq.size(), t, acc + lat);
            end
            checks++;
            if (fq.size() != int'(want_fwd) || (want_fwd && fq[0] !== d0)) begin
                errors++; $display("FAIL rand_fwd n=%0d cnt=%0d want %0d", n, fq.size(), want_fwd);
            end
            checks++;
            if (dq.size() != int'(want_done) || (want_done && dq[0] != acc + lat)) begin
                errors++; $display("FAIL rand_done n=%0d cnt=%0d want %0d at %0d", n, dq.size(), want_done, acc + lat);
            end
            clear_logs();
        end
    endtask

    initial begin
        miss_valid = 1'b0; miss_tag = '0; miss_index = '0; miss_way = 1'b0; miss_blkoff = 1'b0;
        kill = 1'b0; l2_req_ready = 1'b0; l2_resp_valid = 1'b0; l2_resp_data = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_kill();
        test_kill_new_miss();
        test_gapped_stray();
        test_reset_mid_fill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
